dffrf_nr1w: RTL and testbench

//  Parametrised DFF register file: NRD read ports, one write port, depth RCOUNT, width WSIZE.

---
 rtl/dffrf_nr1w.sv | 90 +++++++++
 tb/tb_dffrf_nr1w.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dffrf_nr1w.sv
// rtl/dffrf_nr1w.sv - NRD-read / 1-write DFF register file with post-reset clear sweep.
// Optional write-to-read forwarding is enabled by defining DFFRF_BYPASS_EN.
module dffrf_nr1w #(
   parameter int WSIZE   = 32,
   parameter int RCOUNT  = 32,
   parameter int NRD     = 2,
   parameter int R0_ZERO = 1,
   localparam int AW     = $clog2(RCOUNT)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NRD*AW-1:0]     RA,
   output logic [NRD*WSIZE-1:0]  DR,
   input  logic [AW-1:0]         RW,
   input  logic [WSIZE-1:0]      DW,
   input  logic                  WE,
   output logic                  BUSY
);

`ifdef DFFRF_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam bit              R0Z   = (R0_ZERO != 0);
   localparam logic [AW:0]     DEPTH = (AW+1)'(RCOUNT);
   localparam logic [AW-1:0]   LAST  = AW'(RCOUNT - 1);

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

   state_t                 state_q;
   logic [AW-1:0]          cnt_q;
   logic                   busy_q;
   logic [NRD*WSIZE-1:0]   dr_q;
   logic [NRD*WSIZE-1:0]   dr_d;
   logic [AW-1:0]          ra;
   logic                   wr_commit;
   logic [WSIZE-1:0]       mem [RCOUNT];

   assign wr_commit = (state_q == READY) && WE && ({1'b0, RW} < DEPTH) && !(R0Z && RW == '0);

   // Reads see pre-write contents unless forwarding is built in.
   always_comb begin
      dr_d = '0;
      ra   = '0;
      if (state_q == READY) begin
         for (int i = 0; i < NRD; i++) begin
            ra = RA[i*AW +: AW];
            if (BYPASS && wr_commit && ra == RW)
               dr_d[i*WSIZE +: WSIZE] = DW;
            else if (({1'b0, ra} < DEPTH) && !(R0Z && ra == '0))
               dr_d[i*WSIZE +: WSIZE] = mem[ra];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         dr_q    <= '0;
      end else begin
         dr_q <= dr_d;
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Storage has no reset; the sweep is the only thing that clears it.
   always_ff @(posedge CLK) begin
      if (!RST && state_q == CLEAR)
         mem[cnt_q] <= '0;
      else if (wr_commit)
         mem[RW] <= DW;
   end

   assign DR   = dr_q;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_dffrf_nr1w.sv
// tb/tb_dffrf_nr1w.sv - randomized bench with reference model for two dffrf_nr1w configurations.
module tb_dffrf_nr1w;

`ifdef DFFRF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [9:0]   RA_A = '0;
   logic [19:0]  RA_B = '0;
   logic [63:0]  DR_A;
   logic [127:0] DR_B;
   logic [4:0]   RW = '0;
   logic [31:0]  DW = '0;
   logic         WE = 1'b0;
   logic         BUSY_A, BUSY_B;

   int total = 0;
   int bad   = 0;
   int e     = 0;
   logic [31:0] mem_a [32];
   logic [31:0] mem_b [24];

   always #5 CLK = ~CLK;

   dffrf_nr1w #(.WSIZE(32), .RCOUNT(32), .NRD(2), .R0_ZERO(1)) u_a (
      .CLK(CLK), .RST(RST), .RA(RA_A), .DR(DR_A), .RW(RW), .DW(DW), .WE(WE), .BUSY(BUSY_A));

   dffrf_nr1w #(.WSIZE(32), .RCOUNT(24), .NRD(4), .R0_ZERO(0)) u_b (
      .CLK(CLK), .RST(RST), .RA(RA_B), .DR(DR_B), .RW(RW), .DW(DW), .WE(WE), .BUSY(BUSY_B));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_a(input int a, input bit c, input int w, input logic [31:0] d);
      if (a >= 32 || a == 0) return 32'h0;
      if (BYP && c && a == w) return d;
      return mem_a[a];
   endfunction

   function automatic logic [31:0] ref_b(input int a, input bit c, input int w, input logic [31:0] d);
      if (a >= 24) return 32'h0;
      if (BYP && c && a == w) return d;
      return mem_b[a];
   endfunction

   // Asynchronous reset applied between edges; outputs must clear at once.
   task automatic do_reset();
      RST = 1'b1;
      #1;
      chk("rst_busy_a", 32'(BUSY_A), 32'd1);
      chk("rst_busy_b", 32'(BUSY_B), 32'd1);
      chk("rst_dr_a", DR_A[31:0] | DR_A[63:32], 32'h0);
      chk("rst_dr_b", DR_B[31:0] | DR_B[63:32] | DR_B[95:64] | DR_B[127:96], 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      e = 0;
   endtask

   task automatic cycle(input bit we, input int rw, input logic [31:0] dw,
                        input int a0, input int a1,
                        input int b0, input int b1, input int b2, input int b3);
      logic [31:0] ea [2];
      logic [31:0] eb [4];
      int bs [4];
      bit ca, cb;
      bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
      WE = we;
      RW = rw[4:0];
      DW = dw;
      RA_A = {a1[4:0], a0[4:0]};
      RA_B = {b3[4:0], b2[4:0], b1[4:0], b0[4:0]};
      ca = we && e >= 32 && rw != 0;
      cb = we && e >= 24 && rw < 24;
      ea[0] = (e < 32) ? 32'h0 : ref_a(a0, ca, rw, dw);
      ea[1] = (e < 32) ? 32'h0 : ref_a(a1, ca, rw, dw);
      for (int i = 0; i < 4; i++)
         eb[i] = (e < 24) ? 32'h0 : ref_b(bs[i], cb, rw, dw);
      if (e < 32) mem_a[e] = 32'h0;
      else if (ca) mem_a[rw] = dw;
      if (e < 24) mem_b[e] = 32'h0;
      else if (cb) mem_b[rw] = dw;
      e++;
      @(posedge CLK);
      #1;
      chk("busy_a", 32'(BUSY_A), 32'(e < 32));
      chk("busy_b", 32'(BUSY_B), 32'(e < 24));
      chk("dr_a0", DR_A[31:0], ea[0]);
      chk("dr_a1", DR_A[63:32], ea[1]);
      for (int i = 0; i < 4; i++)
         chk($sformatf("dr_b%0d", i), DR_B[i*32 +: 32], eb[i]);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      do_reset();
      // Writes during the sweep must be ignored.
      for (int i = 0; i < 32; i++) cycle(1'b1, 5, 32'hFFFF_FFFF, 5, 5, 5, 5, 5, 5);
      cycle(1'b0, 0, 0, 5, 5, 5, 5, 5, 5);
      cycle(1'b1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      cycle(1'b0, 0, 0, 7, 7, 7, 7, 7, 7);
      cycle(1'b1, 0, 32'h1234_5678, 1, 1, 1, 1, 1, 1);
      cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1'b1, 3, 32'hA, 0, 0, 0, 0, 0, 0);
      cycle(1'b1, 3, 32'hB, 3, 3, 3, 3, 3, 3);
      cycle(1'b0, 0, 0, 3, 3, 3, 3, 3, 3);
      cycle(1'b1, 30, 32'h5555_AAAA, 30, 30, 30, 30, 30, 30);
      cycle(1'b0, 0, 0, 30, 30, 30, 30, 30, 30);
      cycle(1'b1, 1, 32'h1111_0001, 0, 0, 0, 0, 0, 0);
      cycle(1'b1, 2, 32'h2222_0002, 0, 0, 0, 0, 0, 0);
      cycle(1'b1, 20, 32'h2020_0020, 0, 0, 0, 0, 0, 0);
      cycle(1'b1, 23, 32'h2323_0023, 0, 0, 0, 0, 0, 0);
      cycle(1'b0, 0, 0, 1, 2, 1, 2, 20, 23);
      cycle(1'b0, 0, 0, 23, 31, 23, 24, 31, 0);
      // Reset in the middle of the sweep restarts it.
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 9, 32'hCAFE_0009, 9, 9, 9, 9, 9, 9);
      do_reset();
      for (int i = 0; i < 34; i++) cycle(1'b1, 9, 32'hCAFE_0009, 9, 9, 9, 9, 9, 9);
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
